// File: rtl/hazard_fwd_unit.sv
// Hazard controller for the 5-stage RV32I core: EX operand forwarding selects,
// load-use stalls, branch flushes and the iterative-divider stall sequencer.
//
// state | meaning
// IDLE  | no divide in flight; a divide arriving in E starts the sequence
// BUSY  | divider iterating; E frozen, counter runs down to terminal count
// DONE  | divide result valid this cycle; pipeline advances
module hazard_fwd_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int MDU_CYCLES = 4,
    parameter int CNT_W      = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] rs1_d,
    input  logic [REG_ADDR_W-1:0] rs2_d,
    input  logic [REG_ADDR_W-1:0] rs1_e,
    input  logic [REG_ADDR_W-1:0] rs2_e,
    input  logic [REG_ADDR_W-1:0] rd_e,
    input  logic [REG_ADDR_W-1:0] rd_m,
    input  logic [REG_ADDR_W-1:0] rd_w,
    input  logic                  load_e,
    input  logic                  reg_write_m,
    input  logic                  reg_write_w,
    input  logic                  pc_src_e,
    input  logic                  mdu_start_e,
    output logic [1:0]            forward_a_e,
    output logic [1:0]            forward_b_e,
    output logic                  stall_f,
    output logic                  stall_d,
    output logic                  stall_e,
    output logic                  flush_d,
    output logic                  flush_e,
    output logic                  flush_m,
    output logic                  mdu_busy,
    output logic                  mdu_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mdu_state_t;

    mdu_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             lw_stall;
    logic             mdu_stall;

    function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] rs);
        logic [1:0] sel;
        sel = 2'b00;
        if (reg_write_m && (rd_m != '0) && (rd_m == rs))
            sel = 2'b10;
        else if (reg_write_w && (rd_w != '0) && (rd_w == rs))
            sel = 2'b01;
        return sel;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Loaded with MDU_CYCLES-2: the IDLE start cycle and the final BUSY
    // cycle at terminal count both count toward the stall length.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (mdu_start_e) begin
                    state_nxt = BUSY;
                    cnt_nxt   = CNT_W'(MDU_CYCLES - 2);
                end
            end
            BUSY: begin
                if (cnt == '0)
                    state_nxt = DONE;
                else
                    cnt_nxt = cnt - CNT_W'(1);
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        forward_a_e = fwd_sel(rs1_e);
        forward_b_e = fwd_sel(rs2_e);

        lw_stall  = load_e && (rd_e != '0) && ((rd_e == rs1_d) || (rd_e == rs2_d));
        mdu_stall = ((state == IDLE) && mdu_start_e) || (state == BUSY);

        // A held divide owns E: no flush may destroy it.
        stall_f  = lw_stall | mdu_stall;
        stall_d  = lw_stall | mdu_stall;
        stall_e  = mdu_stall;
        flush_m  = mdu_stall;
        flush_d  = pc_src_e & ~mdu_stall;
        flush_e  = (lw_stall | pc_src_e) & ~mdu_stall;
        mdu_busy = (state == BUSY);
        mdu_done = (state == DONE);
    end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed plus randomized bench for hazard_fwd_unit, checked against a
// cycle-count model of the divider stall window.
module tb_hazard_fwd_unit;

    localparam int RW  = 5;
    localparam int MDU = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [RW-1:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic          load_e, reg_write_m, reg_write_w, pc_src_e, mdu_start_e;
    logic [1:0]    forward_a_e, forward_b_e;
    logic          stall_f, stall_d, stall_e, flush_d, flush_e, flush_m;
    logic          mdu_busy, mdu_done;

    int n_cmp = 0;
    int n_err = 0;
    // cycles elapsed since the divide was accepted; 0 = no divide in flight
    int phase = 0;

    logic [5:0] pat_stall, pat_busy, pat_done;

    always #5 clk = ~clk;

    hazard_fwd_unit #(.REG_ADDR_W(RW), .MDU_CYCLES(MDU), .CNT_W(6)) dut (
        .clk(clk), .rst(rst),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
        .rd_e(rd_e), .rd_m(rd_m), .rd_w(rd_w),
        .load_e(load_e), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
        .pc_src_e(pc_src_e), .mdu_start_e(mdu_start_e),
        .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
        .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e),
        .flush_d(flush_d), .flush_e(flush_e), .flush_m(flush_m),
        .mdu_busy(mdu_busy), .mdu_done(mdu_done)
    );

    task automatic chk(input string tag, input logic [1:0] got, input logic [1:0] exp);
        n_cmp++;
        assert (got === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0b expected %0b", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] model_fwd(input logic [RW-1:0] rs);
        if (reg_write_m && rd_m != 0 && rd_m == rs) return 2'b10;
        if (reg_write_w && rd_w != 0 && rd_w == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic check_all(input string tag);
        logic lw, ms, busy, done;
        lw   = load_e && rd_e != 0 && (rd_e == rs1_d || rd_e == rs2_d);
        busy = (phase >= 1) && (phase < MDU);
        done = (phase == MDU);
        ms   = ((phase == 0) && mdu_start_e) || busy;
        chk({tag, ".fwd_a"},   forward_a_e, model_fwd(rs1_e));
        chk({tag, ".fwd_b"},   forward_b_e, model_fwd(rs2_e));
        chk({tag, ".stall_f"}, {1'b0, stall_f}, {1'b0, lw || ms});
        chk({tag, ".stall_d"}, {1'b0, stall_d}, {1'b0, lw || ms});
        chk({tag, ".stall_e"}, {1'b0, stall_e}, {1'b0, ms});
        chk({tag, ".flush_m"}, {1'b0, flush_m}, {1'b0, ms});
        chk({tag, ".flush_d"}, {1'b0, flush_d}, {1'b0, pc_src_e && !ms});
        chk({tag, ".flush_e"}, {1'b0, flush_e}, {1'b0, (lw || pc_src_e) && !ms});
        chk({tag, ".busy"},    {1'b0, mdu_busy}, {1'b0, busy});
        chk({tag, ".done"},    {1'b0, mdu_done}, {1'b0, done});
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst)               phase = 0;
        else if (phase == 0)   phase = mdu_start_e ? 1 : 0;
        else if (phase < MDU)  phase = phase + 1;
        else                   phase = 0;
        #1;
    endtask

    task automatic zero_inputs();
        rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0; rd_e = 0; rd_m = 0; rd_w = 0;
        load_e = 0; reg_write_m = 0; reg_write_w = 0; pc_src_e = 0; mdu_start_e = 0;
    endtask

    task automatic do_reset();
        zero_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        do_reset();

        // reset state: everything zero
        #1;
        chk("rst.fwd_a", forward_a_e, 2'b00);
        chk("rst.fwd_b", forward_b_e, 2'b00);
        chk("rst.stalls", {1'b0, stall_f | stall_d | stall_e | flush_m}, 2'b00);
        chk("rst.flushes", {1'b0, flush_d | flush_e}, 2'b00);
        chk("rst.mdu", {mdu_busy, mdu_done}, 2'b00);

        // forwarding priority
        rs1_e = 5; rd_m = 5; reg_write_m = 1; rd_w = 5; reg_write_w = 1; #1;
        chk("fwd.mem_wins", forward_a_e, 2'b10);
        check_all("fwd.dbl");
        reg_write_m = 0; #1;
        chk("fwd.wb", forward_a_e, 2'b01);
        rs1_e = 0; rd_m = 0; rd_w = 0; #1;
        chk("fwd.x0", forward_a_e, 2'b00);
        rs2_e = 9; rd_m = 9; reg_write_m = 1; #1;
        chk("fwd.b_mem", forward_b_e, 2'b10);
        tick();

        // load-use
        zero_inputs();
        load_e = 1; rd_e = 7; rs2_d = 7; #1;
        chk("lu.stall_f", {1'b0, stall_f}, 2'b01);
        chk("lu.stall_d", {1'b0, stall_d}, 2'b01);
        chk("lu.flush_e", {1'b0, flush_e}, 2'b01);
        chk("lu.flush_d", {1'b0, flush_d}, 2'b00);
        chk("lu.stall_e", {1'b0, stall_e}, 2'b00);
        rd_e = 0; rs2_d = 0; #1;
        chk("lu.x0", {stall_f, flush_e}, 2'b00);
        tick();

        // branch flush, one cycle only
        zero_inputs();
        pc_src_e = 1; #1;
        chk("br.flush", {flush_d, flush_e}, 2'b11);
        tick();
        pc_src_e = 0; #1;
        chk("br.after", {flush_d, flush_e}, 2'b00);
        tick();

        // divide with start held across cycles 0..5
        do_reset();
        pat_stall = 6'b101111;
        pat_busy  = 6'b001110;
        pat_done  = 6'b010000;
        mdu_start_e = 1;
        for (int c = 0; c < 6; c++) begin
            #1;
            chk($sformatf("mdu.c%0d.stall_e", c), {1'b0, stall_e}, {1'b0, pat_stall[c]});
            chk($sformatf("mdu.c%0d.flush_m", c), {1'b0, flush_m}, {1'b0, pat_stall[c]});
            chk($sformatf("mdu.c%0d.busy", c),    {1'b0, mdu_busy}, {1'b0, pat_busy[c]});
            chk($sformatf("mdu.c%0d.done", c),    {1'b0, mdu_done}, {1'b0, pat_done[c]});
            check_all($sformatf("mdu.c%0d", c));
            tick();
        end

        // branch + load-use while divider busy
        do_reset();
        mdu_start_e = 1; #1;
        check_all("busy.c0");
        tick();
        mdu_start_e = 0; pc_src_e = 1; load_e = 1; rd_e = 3; rs1_d = 3; #1;
        chk("busy.flush", {flush_d, flush_e}, 2'b00);
        chk("busy.stall_f", {1'b0, stall_f}, 2'b01);
        check_all("busy.c1");
        for (int c = 2; c < 6; c++) begin
            tick();
            #1;
            check_all($sformatf("busy.c%0d", c));
        end
        tick();

        // reset mid-divide
        do_reset();
        mdu_start_e = 1; #1; check_all("rbusy.c0"); tick();
        mdu_start_e = 0; #1; check_all("rbusy.c1"); tick();
        rst = 1; #1; check_all("rbusy.c2"); tick();
        rst = 0; #1;
        chk("rbusy.c3.busy", {1'b0, mdu_busy}, 2'b00);
        chk("rbusy.c3.stalls", {stall_f, stall_e}, 2'b00);
        check_all("rbusy.c3");
        tick();

        // randomized traffic
        do_reset();
        for (int i = 0; i < 400; i++) begin
            rs1_d = RW'($urandom_range(0, 3)); rs2_d = RW'($urandom_range(0, 3));
            rs1_e = RW'($urandom_range(0, 3)); rs2_e = RW'($urandom_range(0, 3));
            rd_e  = RW'($urandom_range(0, 3)); rd_m  = RW'($urandom_range(0, 3));
            rd_w  = RW'($urandom_range(0, 3));
            load_e      = 1'($urandom_range(0, 1));
            reg_write_m = 1'($urandom_range(0, 1));
            reg_write_w = 1'($urandom_range(0, 1));
            pc_src_e    = ($urandom_range(0, 3) == 0);
            mdu_start_e = ($urandom_range(0, 3) == 0);
            rst         = ($urandom_range(0, 49) == 0);
            #1;
            check_all($sformatf("rnd%0d", i));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_fwd_unit.md
Name: hazard_fwd_unit

Overview:
- Pipeline hazard controller for the 5-stage RV32I core.
- Generates the 2-bit forwarding selects that drive the Execute-stage operand mux3 instances: 00 = register file, 01 = Writeback result, 10 = Memory ALU result.
- Also generates load-use stalls, branch/jump flushes, and a multi-cycle stall sequencer for the iterative divider (MDU) in Execute.

Parameters:
REG_ADDR_W, 5, register index width
MDU_CYCLES, 4, total Execute stall cycles per divide op; legal range 2..64
CNT_W, 6, MDU counter width; must satisfy 2^CNT_W > MDU_CYCLES

Ports:
clk  in  1  core clock, rising edge
rst  in  1  synchronous active-high reset
rs1_d  in  REG_ADDR_W  Decode source 1
rs2_d  in  REG_ADDR_W  Decode source 2
rs1_e  in  REG_ADDR_W  Execute source 1
rs2_e  in  REG_ADDR_W  Execute source 2
rd_e  in  REG_ADDR_W  Execute destination
rd_m  in  REG_ADDR_W  Memory destination
rd_w  in  REG_ADDR_W  Writeback destination
load_e  in  1  Execute instruction is a load
reg_write_m  in  1  Memory stage writes rd_m
reg_write_w  in  1  Writeback stage writes rd_w
pc_src_e  in  1  taken branch/jump resolved in Execute
mdu_start_e  in  1  divide/remainder op present in Execute
forward_a_e  out  2  select for operand-A mux3
forward_b_e  out  2  select for operand-B mux3
stall_f  out  1  hold PC
stall_d  out  1  hold IF/ID register
stall_e  out  1  hold ID/EX register
flush_d  out  1  clear IF/ID register
flush_e  out  1  clear ID/EX register
flush_m  out  1  insert bubble into EX/MEM register
mdu_busy  out  1  FSM in BUSY
mdu_done  out  1  divide result valid this cycle

Behaviour:
- Reset: state = IDLE, cnt = 0. Outputs are combinational from inputs and state.
  - With all inputs 0 after reset, every output is 0.
  - forward_* is never 11.
- Forwarding (combinational, per operand; shown for A, B is identical using rs2_e):
  - 10 if reg_write_m & rd_m != 0 & rd_m == rs1_e;
  - else 01 if reg_write_w & rd_w != 0 & rd_w == rs1_e;
  - else 00.
  - Memory beats Writeback on a double match.
- lw_stall = load_e & rd_e != 0 & (rd_e == rs1_d | rd_e == rs2_d).
- mdu_stall = (state == IDLE & mdu_start_e) | state == BUSY.
- Control outputs:
  - stall_f = stall_d = lw_stall | mdu_stall
  - stall_e = mdu_stall
  - flush_m = mdu_stall
  - flush_d = pc_src_e & ~mdu_stall
  - flush_e = (lw_stall | pc_src_e) & ~mdu_stall
  - mdu_stall dominates: the divide stays frozen in Execute; no E flush while it is held.
- MDU FSM (registered):
  - IDLE: if mdu_start_e, go to BUSY with cnt = MDU_CYCLES-2.
  - BUSY: if cnt == 0, go to DONE; else cnt = cnt-1.
  - DONE: go to IDLE unconditionally. mdu_start_e is ignored in DONE because the same divide is still in E and is advancing.
- MDU timing:
  - Stall is high for exactly MDU_CYCLES consecutive cycles, starting in the cycle mdu_start_e is first seen in IDLE.
  - mdu_done is high for 1 cycle, in the DONE cycle; stalls are low in that cycle.
  - mdu_busy = (state == BUSY).
- Back-to-back divides: a second divide arriving in E the cycle after DONE sees IDLE and restarts normally.
- Simultaneous lw_stall and MDU start: stalls OR together. The load in D re-evaluates after the divide leaves E.
- Reset during BUSY: next cycle IDLE, cnt = 0, all stalls drop.

Test Plan:
- rs1_e=5, rd_m=5, reg_write_m=1, rd_w=5, reg_write_w=1 -> forward_a_e=10. Drop reg_write_m -> 01. Set rs1_e=rd_m=rd_w=0 -> 00.
- load_e=1, rd_e=7, rs2_d=7 -> stall_f=stall_d=flush_e=1, flush_d=0. Repeat with rd_e=0 -> all 0.
- pc_src_e=1, no stall -> flush_d=flush_e=1 for that cycle only.
- MDU_CYCLES=4, mdu_start_e held high from cycle 0 -> stall_e/flush_m high cycles 0-3, mdu_busy high cycles 1-3, mdu_done high cycle 4 with stalls low, IDLE at cycle 5. Start held through cycle 5 -> new sequence begins at cycle 5.
- During BUSY, assert pc_src_e=1 and a load-use match -> flush_d=flush_e=0, stall_f=1.
- rst=1 in cycle 2 of a divide -> cycle 3: mdu_busy=0, stalls 0 with mdu_start_e=0.
